// File: rtl/ct_loader_pkg.sv
// Shared types and constants for the ciphertext loader.
// Holds the FSM state encoding, bus widths and the length-byte acceptance rule.
// No logic beyond a pure combinational helper function.
package ct_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LAUNCH,
        WAIT_DROP,
        WAIT_DONE
    } state_t;

    localparam int                   CT_ADDR_W = 8;
    localparam int                   KEY_W     = 24;
    localparam logic [CT_ADDR_W-1:0] LEN_ADDR  = 8'h00;

    // A length byte is usable only if it describes a non-empty message that fits.
    function automatic logic len_ok(input logic [7:0] len, input logic [7:0] max_len);
        return (len != 8'd0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/ct_loader.sv
// Purpose: loads a length-prefixed ciphertext stream into CT memory, launches the cracker, holds its result.
// Latency: each accepted byte is written 1 cycle later; crack_en rises L+2 cycles after the length byte.
// Backpressure: in_ready is high only in IDLE/LOAD; a bubble on in_valid simply stalls the load.
//
// Ports:
//   clk, rst                 - clock and asynchronous active-high reset
//   in_data/in_valid/in_ready - byte stream; first byte is L, then L ciphertext bytes
//   ct_addr/ct_wrdata/ct_wren - registered CT memory write port (length at 0, bytes at 1..L)
//   crack_en/crack_rdy       - start handshake with the cracker
//   crack_key/crack_key_valid - cracker result, sampled when it returns ready
//   key/key_valid/done       - held result, cleared when the next valid length byte is accepted
//   err                      - one-cycle pulse for a rejected length byte
module ct_loader
    import ct_loader_pkg::*;
#(
    parameter int MAX_LEN = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [CT_ADDR_W-1:0] ct_addr,
    output logic [7:0]           ct_wrdata,
    output logic                 ct_wren,
    output logic                 crack_en,
    input  logic                 crack_rdy,
    input  logic [KEY_W-1:0]     crack_key,
    input  logic                 crack_key_valid,
    output logic [KEY_W-1:0]     key,
    output logic                 key_valid,
    output logic                 done,
    output logic                 err
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t               state_q, state_d;
    logic [7:0]           len_q, len_d;
    logic [CT_ADDR_W-1:0] cnt_q, cnt_d;
    logic [CT_ADDR_W-1:0] cnt_nxt;
    logic                 ct_wren_q, ct_wren_d;
    logic [CT_ADDR_W-1:0] ct_addr_q, ct_addr_d;
    logic [7:0]           ct_wrdata_q, ct_wrdata_d;
    logic                 crack_en_q, crack_en_d;
    logic [KEY_W-1:0]     key_q, key_d;
    logic                 key_valid_q, key_valid_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 accept;

    assign in_ready = (state_q == IDLE) || (state_q == LOAD);
    assign accept   = in_valid && in_ready;
    // cnt_q is the address of the last byte written; the next data byte goes one above it.
    assign cnt_nxt  = cnt_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        ct_wren_d   = 1'b0;
        ct_addr_d   = ct_addr_q;
        ct_wrdata_d = ct_wrdata_q;
        crack_en_d  = 1'b0;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        done_d      = done_q;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (len_ok(in_data, MAX_LEN_B)) begin
                        len_d       = in_data;
                        cnt_d       = LEN_ADDR;
                        ct_wren_d   = 1'b1;
                        ct_addr_d   = LEN_ADDR;
                        ct_wrdata_d = in_data;
                        done_d      = 1'b0;
                        key_d       = '0;
                        key_valid_d = 1'b0;
                        state_d     = LOAD;
                    end else begin
                        // Rejected length: leave the held result untouched.
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    cnt_d       = cnt_nxt;
                    ct_wren_d   = 1'b1;
                    ct_addr_d   = cnt_nxt;
                    ct_wrdata_d = in_data;
                    if (cnt_nxt == len_q) begin
                        state_d = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                // crack_en is registered, so it first rises one cycle after the last
                // write strobe; the launch is the first cycle it meets crack_rdy.
                if (crack_en_q && crack_rdy) begin
                    state_d = WAIT_DROP;
                end else begin
                    crack_en_d = 1'b1;
                end
            end
            WAIT_DROP: begin
                if (!crack_rdy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (crack_rdy) begin
                    key_d       = crack_key;
                    key_valid_d = crack_key_valid;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            ct_wren_q   <= 1'b0;
            ct_addr_q   <= '0;
            ct_wrdata_q <= '0;
            crack_en_q  <= 1'b0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            ct_wren_q   <= ct_wren_d;
            ct_addr_q   <= ct_addr_d;
            ct_wrdata_q <= ct_wrdata_d;
            crack_en_q  <= crack_en_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign ct_wren   = ct_wren_q;
    assign ct_addr   = ct_addr_q;
    assign ct_wrdata = ct_wrdata_q;
    assign crack_en  = crack_en_q;
    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
